// File: rtl/spi_rx_multitrig.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_rx_multitrig                                             |
// | Description : Passive SPI bus sniffer. Shifts MOSI bits while SS_n is low, |
// |               then at frame end checks the bit count and evaluates NUM_CH  |
// |               independent mask/match trigger channels.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spi_rx_multitrig #(
    parameter int DATA_W      = 32,
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    localparam int CNT_W      = $clog2(DATA_W + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     SS_n,
    input  logic                     SCLK,
    input  logic                     MOSI,
    input  logic                     edg,
    input  logic [CNT_W-1:0]         frame_len,
    input  logic [NUM_CH-1:0]        ch_en,
    input  logic [NUM_CH*DATA_W-1:0] mask,
    input  logic [NUM_CH*DATA_W-1:0] match,
    output logic [NUM_CH-1:0]        trig_vec,
    output logic                     SPItrig,
    output logic                     frame_vld,
    output logic                     frame_err,
    output logic [DATA_W-1:0]        frame_data
);

    localparam logic [CNT_W-1:0] c_DATA_W_CNT = CNT_W'(DATA_W);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RX   = 2'd1,
        ST_EVAL = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Synchronisers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_sync_vld;
    logic                   r_sclk_d;
    logic                   r_mosi_d;
    logic                   r_ss_d;

    logic w_ss_s;
    logic w_sclk_s;
    logic w_mosi_s;
    logic w_rise;
    logic w_fall;
    logic w_smp;
    logic w_ss_fall;

    // Bring the async SPI pins into the clk domain; SS_n idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ss_sync   <= '1;
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_mosi_d    <= 1'b0;
        end else begin
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SS_n};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
            r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
            r_mosi_d    <= r_mosi_sync[SYNC_STAGES-1];
        end
    end

    // Track when the SS_n chain holds real pin samples, and remember the
    // previous SS_n level. r_ss_d only becomes 1 once SS_n has really been
    // seen high, so a frame already in progress at reset release is skipped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_vld <= '0;
            r_ss_d     <= 1'b0;
        end else begin
            r_sync_vld <= {r_sync_vld[SYNC_STAGES-2:0], 1'b1};
            r_ss_d     <= r_sync_vld[SYNC_STAGES-1] & w_ss_s;
        end
    end

    assign w_ss_s    = r_ss_sync[SYNC_STAGES-1];
    assign w_sclk_s  = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi_s  = r_mosi_d;
    assign w_rise    = ~r_sclk_d & w_sclk_s;
    assign w_fall    = r_sclk_d & ~w_sclk_s;
    assign w_smp     = edg ? w_rise : w_fall;
    assign w_ss_fall = r_ss_d & ~w_ss_s;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t r_state;
    state_t w_state_nxt;
    logic   w_start;
    logic   w_shift;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; SS_n returning high takes priority over a sample edge.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ss_fall) begin
                    w_state_nxt = ST_RX;
                    w_start     = 1'b1;
                end
            end
            ST_RX: begin
                if (w_ss_s) begin
                    w_state_nxt = ST_EVAL;
                end else if (w_smp) begin
                    w_shift = 1'b1;
                end
            end
            ST_EVAL: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shift register and saturating bit counter
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_sr;
    logic [CNT_W-1:0]  r_bit_cnt;

    // Shift MSB-first; overflow bits fall off the top of the register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr      <= '0;
            r_bit_cnt <= '0;
        end else if (w_start) begin
            r_sr      <= '0;
            r_bit_cnt <= '0;
        end else if (w_shift) begin
            r_sr <= {r_sr[DATA_W-2:0], w_mosi_s};
            if (r_bit_cnt != '1) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame evaluation
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]  w_len;
    logic [DATA_W-1:0] w_lmask;
    logic              w_len_ok;
    logic [NUM_CH-1:0] w_hit;

    // Effective length and the mask of bit positions inside it.
    always_comb begin
        w_len = frame_len;
        if ((frame_len == '0) || (frame_len > c_DATA_W_CNT)) begin
            w_len = c_DATA_W_CNT;
        end
        w_lmask = '0;
        for (int j = 0; j < DATA_W; j++) begin
            w_lmask[j] = (j < int'(w_len));
        end
    end

    assign w_len_ok = (r_bit_cnt == w_len);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [DATA_W-1:0] w_diff;
            assign w_diff = (r_sr ^ match[gi*DATA_W +: DATA_W])
                          & ~mask[gi*DATA_W +: DATA_W] & w_lmask;
            assign w_hit[gi] = ch_en[gi] & ~(|w_diff) & w_len_ok;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] r_trig_vec;
    logic              r_spitrig;
    logic              r_frame_vld;
    logic              r_frame_err;
    logic [DATA_W-1:0] r_frame_data;

    // Single-cycle result pulses in EVAL; frame_data holds between frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_trig_vec   <= '0;
            r_spitrig    <= 1'b0;
            r_frame_vld  <= 1'b0;
            r_frame_err  <= 1'b0;
            r_frame_data <= '0;
        end else begin
            r_trig_vec  <= '0;
            r_spitrig   <= 1'b0;
            r_frame_vld <= 1'b0;
            r_frame_err <= 1'b0;
            if (r_state == ST_EVAL) begin
                r_trig_vec   <= w_hit;
                r_spitrig    <= |w_hit;
                r_frame_vld  <= 1'b1;
                r_frame_err  <= ~w_len_ok;
                r_frame_data <= r_sr & w_lmask;
            end
        end
    end

    assign trig_vec   = r_trig_vec;
    assign SPItrig    = r_spitrig;
    assign frame_vld  = r_frame_vld;
    assign frame_err  = r_frame_err;
    assign frame_data = r_frame_data;

endmodule
`default_nettype wire
